// File: rtl/reg_bank_ctrl_if.sv
// Instruction handshake bus between an instruction source and reg_bank_ctrl.
// The master offers a micro-instruction and its write operand. The slave
// (the controller) signals when it can accept them.
interface reg_bank_ctrl_if #(
  parameter int DW = 64
);

  logic [15:0]   instr;
  logic [DW-1:0] wdata;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    output instr,
    output wdata,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  wdata,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: sequencer placed directly in front of reg_bank.
// Each accepted micro-instruction (op/half/dst/srcA/srcB) plus a write
// operand is expanded into the strobe sequence that reg_bank expects.
//   NOP   : ND
//   WRITE : W1 -> W2        (regwe held two cycles)
//   READ  : RD -> RV        (enrreg, then result valid)
//   CONST : C1 -> C2 -> RV  (cnst held two cycles, enrreg in the second)
// Data and select outputs come only from the handshake latches. They keep
// their values until the next handshake.
module reg_bank_ctrl #(
  parameter int DW = 64
) (
  input  logic          clock,
  input  logic          reset,
  reg_bank_ctrl_if.slave bus,
  output logic          regwe,
  output logic [DW-1:0] inA,
  output logic [3:0]    selwreg,
  output logic [1:0]    endreg,
  output logic [3:0]    seloutA,
  output logic [3:0]    seloutB,
  output logic          cnstA,
  output logic          cnstB,
  output logic          enrregA,
  output logic          enrregB,
  output logic          res_valid,
  output logic          done
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CONST = 2'b11;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ND   = 3'd1;
  localparam logic [2:0] W1   = 3'd2;
  localparam logic [2:0] W2   = 3'd3;
  localparam logic [2:0] RD   = 3'd4;
  localparam logic [2:0] C1   = 3'd5;
  localparam logic [2:0] C2   = 3'd6;
  localparam logic [2:0] RV   = 3'd7;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       hs;

  logic [1:0] instr_op;
  logic [1:0] instr_half;
  logic [3:0] instr_dst;
  logic [3:0] instr_srca;
  logic [3:0] instr_srcb;

  assign instr_op   = bus.instr[15:14];
  assign instr_half = bus.instr[13:12];
  assign instr_dst  = bus.instr[11:8];
  assign instr_srca = bus.instr[7:4];
  assign instr_srcb = bus.instr[3:0];

  // Ready is a pure function of state, so there is no path from valid to ready.
  assign bus.instr_ready = (state == IDLE);
  assign hs              = bus.instr_valid && bus.instr_ready;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: the opcode only matters on the handshake edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
          case (instr_op)
            OP_NOP:   state_nxt = ND;
            OP_WRITE: state_nxt = W1;
            OP_READ:  state_nxt = RD;
            OP_CONST: state_nxt = C1;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      ND:      state_nxt = IDLE;
      W1:      state_nxt = W2;
      W2:      state_nxt = IDLE;
      RD:      state_nxt = RV;
      C1:      state_nxt = C2;
      C2:      state_nxt = RV;
      RV:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake latches that drive all data/select outputs to reg_bank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inA     <= '0;
      selwreg <= '0;
      endreg  <= '0;
      seloutA <= '0;
      seloutB <= '0;
    end else if (hs) begin
      inA     <= bus.wdata;
      selwreg <= instr_dst;
      endreg  <= instr_half;
      seloutA <= instr_srca;
      seloutB <= instr_srcb;
    end
  end

  // Moore strobe decode, so strobes drop as soon as reset forces IDLE.
  always_comb begin
    regwe     = 1'b0;
    cnstA     = 1'b0;
    cnstB     = 1'b0;
    enrregA   = 1'b0;
    enrregB   = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state)
      ND: begin
        done = 1'b1;
      end
      W1: begin
        regwe = 1'b1;
      end
      W2: begin
        regwe = 1'b1;
        done  = 1'b1;
      end
      RD: begin
        enrregA = 1'b1;
        enrregB = 1'b1;
      end
      C1: begin
        cnstA = 1'b1;
        cnstB = 1'b1;
      end
      C2: begin
        // Constant select stays up so the output register captures a settled value.
        cnstA   = 1'b1;
        cnstB   = 1'b1;
        enrregA = 1'b1;
        enrregB = 1'b1;
      end
      RV: begin
        res_valid = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: a table of instructions with hand-written
// per-cycle strobe sequences, plus sequences for reset, held-valid and abort.
module tb_reg_bank_ctrl;

  localparam int DW = 64;

  logic          clock;
  logic          reset;
  logic          regwe;
  logic [DW-1:0] inA;
  logic [3:0]    selwreg;
  logic [1:0]    endreg;
  logic [3:0]    seloutA;
  logic [3:0]    seloutB;
  logic          cnstA;
  logic          cnstB;
  logic          enrregA;
  logic          enrregB;
  logic          res_valid;
  logic          done;

  reg_bank_ctrl_if #(.DW(DW)) bus ();

  reg_bank_ctrl #(.DW(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .regwe     (regwe),
    .inA       (inA),
    .selwreg   (selwreg),
    .endreg    (endreg),
    .seloutA   (seloutA),
    .seloutB   (seloutB),
    .cnstA     (cnstA),
    .cnstB     (cnstB),
    .enrregA   (enrregA),
    .enrregB   (enrregB),
    .res_valid (res_valid),
    .done      (done)
  );

  // Strobe word: {regwe, cnstA, cnstB, enrregA, enrregB, res_valid, done, instr_ready}
  logic [7:0] stb;
  assign stb = {regwe, cnstA, cnstB, enrregA, enrregB, res_valid, done, bus.instr_ready};

  localparam logic [7:0] S_IDLE = 8'h01;
  localparam logic [7:0] S_ND   = 8'h02;
  localparam logic [7:0] S_W1   = 8'h80;
  localparam logic [7:0] S_W2   = 8'h82;
  localparam logic [7:0] S_RD   = 8'h18;
  localparam logic [7:0] S_C1   = 8'h60;
  localparam logic [7:0] S_C2   = 8'h78;
  localparam logic [7:0] S_RV   = 8'h06;

  typedef struct {
    string          name;
    logic [1:0]     op;
    logic [1:0]     half;
    logic [3:0]     dst;
    logic [3:0]     sa;
    logic [3:0]     sb;
    logic [63:0]    wd;
    int             n;
    logic [0:2][7:0] seq;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(string name, logic [1:0] op, logic [1:0] half, logic [3:0] dst,
                              logic [3:0] sa, logic [3:0] sb, logic [63:0] wd, int n,
                              logic [7:0] s0, logic [7:0] s1, logic [7:0] s2);
    vec_t v;
    v.name = name; v.op = op; v.half = half; v.dst = dst; v.sa = sa; v.sb = sb;
    v.wd = wd; v.n = n; v.seq = {s0, s1, s2};
    return v;
  endfunction

  // Called in an IDLE cycle; returns in the IDLE cycle right after done.
  task automatic run_vec(input vec_t v);
    chk({v.name, " idle"}, {56'd0, stb}, {56'd0, S_IDLE});
    bus.instr       = {v.op, v.half, v.dst, v.sa, v.sb};
    bus.wdata       = v.wd;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom_range(0, 16'hffff);
    bus.wdata       = {$urandom, $urandom};
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("%s stb[%0d]", v.name, i), {56'd0, stb}, {56'd0, v.seq[i]});
      if (i == v.n - 1) begin
        chk({v.name, " inA"},     inA,             v.wd);
        chk({v.name, " selwreg"}, {60'd0, selwreg}, {60'd0, v.dst});
        chk({v.name, " endreg"},  {62'd0, endreg},  {62'd0, v.half});
        chk({v.name, " seloutA"}, {60'd0, seloutA}, {60'd0, v.sa});
        chk({v.name, " seloutB"}, {60'd0, seloutB}, {60'd0, v.sb});
      end
      step();
    end
  endtask

  initial begin
    // Vector table.
    vt.push_back(mk("wr5",   2'b01, 2'b00, 4'd5, 4'd0, 4'd0, 64'h4, 2, S_W1, S_W2, 8'h00));
    vt.push_back(mk("rd5",   2'b10, 2'b00, 4'd0, 4'd5, 4'd0, 64'h0, 2, S_RD, S_RV, 8'h00));
    for (int d = 0; d < 16; d++)
      vt.push_back(mk($sformatf("wrall%0d", d), 2'b01, 2'(d % 4), 4'(d), 4'(15 - d), 4'(d),
                      64'(d + 1), 2, S_W1, S_W2, 8'h00));
    for (int d = 0; d < 16; d++)
      vt.push_back(mk($sformatf("rdall%0d", d), 2'b10, 2'b00, 4'd0, 4'(d), 4'(15 - d),
                      64'hdead_0000 + 64'(d), 2, S_RD, S_RV, 8'h00));
    vt.push_back(mk("cst4",  2'b11, 2'b00, 4'd0, 4'b0100, 4'b0100, 64'h0, 3, S_C1, S_C2, S_RV));
    vt.push_back(mk("cst5",  2'b11, 2'b00, 4'd0, 4'b0101, 4'b0101, 64'h0, 3, S_C1, S_C2, S_RV));
    vt.push_back(mk("cst10", 2'b11, 2'b00, 4'd0, 4'b1010, 4'b1010, 64'h0, 3, S_C1, S_C2, S_RV));
    vt.push_back(mk("cst15", 2'b11, 2'b00, 4'd0, 4'b1111, 4'b1111, 64'h0, 3, S_C1, S_C2, S_RV));
    vt.push_back(mk("nop",   2'b00, 2'b10, 4'd9, 4'd3, 4'd12, 64'hcafe_f00d_1234_5678, 1,
                    S_ND, 8'h00, 8'h00));
    vt.push_back(mk("wrhalf", 2'b01, 2'b10, 4'd14, 4'd1, 4'd2, 64'hffff_ffff_ffff_ffff, 2,
                    S_W1, S_W2, 8'h00));

    // Reset held with valid asserted: nothing is accepted.
    reset           = 1'b0;
    bus.instr       = {2'b01, 2'b01, 4'd7, 4'd0, 4'd0};
    bus.wdata       = 64'h77;
    bus.instr_valid = 1'b1;
    #1;
    chk("rst stb", {56'd0, stb}, {56'd0, S_IDLE});
    chk("rst inA", inA, 64'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("rst hold stb %0d", i), {56'd0, stb}, {56'd0, S_IDLE});
      chk($sformatf("rst hold selwreg %0d", i), {60'd0, selwreg}, 64'd0);
    end
    reset = 1'b1;
    step();
    chk("post rst W1", {56'd0, stb}, {56'd0, S_W1});
    chk("post rst selwreg", {60'd0, selwreg}, 64'd7);
    chk("post rst endreg", {62'd0, endreg}, 64'd1);
    bus.instr_valid = 1'b0;
    step();
    chk("post rst W2", {56'd0, stb}, {56'd0, S_W2});
    step();

    // Table-driven vectors, issued back to back.
    foreach (vt[i]) run_vec(vt[i]);

    // Valid held high with changing instr/wdata.
    bus.instr_valid = 1'b1;
    bus.instr       = {2'b01, 2'b00, 4'd3, 4'd0, 4'd0};
    bus.wdata       = 64'haaaa_aaaa_aaaa_aaaa;
    step();
    chk("hold W1", {56'd0, stb}, {56'd0, S_W1});
    bus.instr = {2'b10, 2'b00, 4'd0, 4'd9, 4'd2};
    bus.wdata = 64'hbbbb_bbbb_bbbb_bbbb;
    step();
    chk("hold W2", {56'd0, stb}, {56'd0, S_W2});
    chk("hold inA W2", inA, 64'haaaa_aaaa_aaaa_aaaa);
    chk("hold seloutA W2", {60'd0, seloutA}, 64'd0);
    step();
    chk("hold idle", {56'd0, stb}, {56'd0, S_IDLE});
    step();
    chk("hold RD", {56'd0, stb}, {56'd0, S_RD});
    chk("hold seloutA RD", {60'd0, seloutA}, 64'd9);
    chk("hold inA RD", inA, 64'hbbbb_bbbb_bbbb_bbbb);
    bus.instr = {2'b00, 2'b00, 4'd1, 4'd1, 4'd1};
    step();
    chk("hold RV", {56'd0, stb}, {56'd0, S_RV});
    step();
    chk("hold idle2", {56'd0, stb}, {56'd0, S_IDLE});
    step();
    chk("hold ND", {56'd0, stb}, {56'd0, S_ND});
    chk("hold ND selwreg", {60'd0, selwreg}, 64'd1);
    bus.instr_valid = 1'b0;
    step();
    chk("hold idle3", {56'd0, stb}, {56'd0, S_IDLE});

    // Reset during C1 aborts without waiting for a clock edge.
    bus.instr       = {2'b11, 2'b00, 4'd0, 4'b0101, 4'b0101};
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("abort C1", {56'd0, stb}, {56'd0, S_C1});
    #2;
    reset = 1'b0;
    #1;
    chk("abort async", {56'd0, stb}, {56'd0, S_IDLE});
    chk("abort seloutB", {60'd0, seloutB}, 64'd0);
    step();
    chk("abort held", {56'd0, stb}, {56'd0, S_IDLE});
    reset = 1'b1;
    step();
    chk("abort no rv", {56'd0, stb}, {56'd0, S_IDLE});
    run_vec(mk("rdpost", 2'b10, 2'b00, 4'd0, 4'd5, 4'd6, 64'h0, 2, S_RD, S_RV, 8'h00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Sequencer that sits directly upstream of `reg_bank` and generates every control and data input it needs. Accepts one 16-bit micro-instruction plus a 64-bit write operand per valid/ready handshake. Expands it into the multi-cycle strobe sequences that `reg_bank` requires: write, read into the output registers, or constant generation. Flags the cycle in which `reg_bank`'s `outA`/`outB` are valid for downstream consumers.

## Interface
- `DW`, 64, data width; must equal the `reg_bank` width
- `clock`  in  1  master clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `instr`  in  16  micro-instruction: [15:14] op, [13:12] half, [11:8] dst, [7:4] srcA, [3:0] srcB
- `wdata`  in  DW  write operand; sampled with `instr`
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  controller idle; handshake completes on a rising edge with valid&ready
- `regwe`  out  1  to `reg_bank`
- `inA`  out  DW  to `reg_bank`
- `selwreg`  out  4  to `reg_bank`
- `endreg`  out  2  to `reg_bank`
- `seloutA`, `seloutB`  out  4 each  to `reg_bank`
- `cnstA`, `cnstB`  out  1 each  to `reg_bank`
- `enrregA`, `enrregB`  out  1 each  to `reg_bank`
- `res_valid`  out  1  one-cycle pulse; `reg_bank` `outA`/`outB` hold the result of the last READ/CONST
- `done`  out  1  one-cycle pulse at the last cycle of every instruction

## Operation
- Op codes:
  - 00 NOP
  - 01 WRITE: `wdata` → register `dst`, half-enable = `half`
  - 10 READ: load `srcA` into output register A and `srcB` into output register B
  - 11 CONST: load constant codes `srcA`/`srcB` into output registers A/B
- On handshake, latch the instruction and `wdata` into internal registers. Drive outputs from the latches only:
  - `inA` = wdata
  - `selwreg` = dst
  - `endreg` = half, passed unchanged; half-word semantics are owned by `reg_bank`
  - `seloutA` = srcA
  - `seloutB` = srcB
- Data/select outputs hold their values after the instruction ends and change only at the next handshake.
- Strobe outputs (`regwe`, `cnstA/B`, `enrregA/B`, `res_valid`, `done`) are 0 outside the states listed below.
- `instr_ready` = 1 only in IDLE; combinational from state.
- State transitions:
  - IDLE → (handshake) NOP→ND, WRITE→W1, READ→RD, CONST→C1
  - ND: `done`=1 → IDLE
  - W1: `regwe`=1 → W2
  - W2: `regwe`=1, `done`=1 → IDLE
  - RD: `enrregA`=`enrregB`=1 → RV
  - C1: `cnstA`=`cnstB`=1 → C2
  - C2: `cnstA`=`cnstB`=1, `enrregA`=`enrregB`=1 → RV
  - RV: `res_valid`=1, `done`=1 → IDLE
- `instr_valid` while not ready is ignored; `instr`/`wdata` changes outside the handshake have no effect.
- Back-to-back instructions are allowed. Each new handshake can occur in the IDLE cycle after `done`, with no extra bubble.

## Timing
- Reset: all outputs 0 except `instr_ready`=1; state IDLE. Assertion mid-instruction aborts it immediately: strobes drop asynchronously and no `done`/`res_valid` is issued.
- Handshake at edge N puts the FSM in its first op state during cycle N..N+1.
- Cycles from handshake to `done` (inclusive of the `done` cycle):
  - NOP: 1
  - WRITE: 2
  - READ: 2
  - CONST: 3
- Instruction throughput, including the IDLE cycle:
  - NOP: 2 cycles
  - WRITE: 3 cycles
  - READ: 3 cycles
  - CONST: 4 cycles
- `res_valid` is asserted in the cycle after the last `enrreg` cycle. `reg_bank` output registers update on the edge ending RD/C2, so `outA`/`outB` are stable during the whole RV cycle.
- `cnstA/B` stay high through C2 so the constant path is settled when the `reg_bank` output register captures.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `instr_valid`=1 → all strobes 0, `instr_ready`=1, no handshake taken; after release, first edge with valid accepts.
- Write/read: WRITE dst=5 half=00 wdata=64'h4, then READ srcA=5 srcB=0, with `reg_bank` instantiated → `regwe` high exactly 2 cycles with `selwreg`=5; `res_valid` 2 cycles after the READ handshake with `outA`=64'h4.
- All registers: loop over dst 0..15 writing dst+1, then READ each → `outA` equals dst+1 on every `res_valid`; every `done` spacing is 3 cycles.
- Constants: CONST srcB=4'b0100, 4'b0101, 4'b1010, 4'b1111 → on `res_valid`, `outB` = 64'h1, 64'h00000000ffffffff, 64'hffffffff00000000, 64'hffffffffffffffff respectively; `cnstB` high exactly 2 cycles, `enrregB` only in the second.
- Handshake: `instr_valid` held high continuously with changing `instr` → an instruction is accepted only on IDLE edges; a NOP gives `done` 1 cycle after its handshake; `wdata` changed during W1 does not alter `inA`.
- Abort: assert `reset` during C1 → `cnstA/B` drop without waiting for a clock edge; no `res_valid`; after release, a READ completes normally.
